pipe_stage_reg: RTL

//  Generic pipeline-stage register with valid/ready handshake, flush and optional skid buffer.

---
 rtl/pipe_pkg.sv | 66 ++++++
 rtl/pipe_skid_buf.sv | 36 +++
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline payload layout and helpers
// Purpose: field layout of the ID/EX stage payload (LSB/MSB per field),
//          its total width, and pack/unpack helpers between the struct
//          view and the flat vector carried by pipe_stage_reg.
// Ports:   none (package).
package pipe_pkg;

    typedef struct packed {
        logic [31:0] final_a;
        logic [31:0] final_b;
        logic [31:0] pc_plus_4;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic [1:0]  wb_select;
        logic [1:0]  write_width;
        logic        sub;
        logic        slt_signed;
        logic        slt_unsigned;
        logic        word_op;
        logic        is_write_dmem;
        logic        pc_sel;
    } id_ex_t;

    localparam int ID_EX_PAYLOAD_W = $bits(id_ex_t);

    // Packed structs place the first member at the MSB, so the chain
    // starts from pc_sel at bit 0.
    localparam int PC_SEL_LSB        = 0;
    localparam int PC_SEL_MSB        = PC_SEL_LSB;
    localparam int IS_WRITE_DMEM_LSB = PC_SEL_MSB + 1;
    localparam int IS_WRITE_DMEM_MSB = IS_WRITE_DMEM_LSB;
    localparam int WORD_OP_LSB       = IS_WRITE_DMEM_MSB + 1;
    localparam int WORD_OP_MSB       = WORD_OP_LSB;
    localparam int SLT_UNSIGNED_LSB  = WORD_OP_MSB + 1;
    localparam int SLT_UNSIGNED_MSB  = SLT_UNSIGNED_LSB;
    localparam int SLT_SIGNED_LSB    = SLT_UNSIGNED_MSB + 1;
    localparam int SLT_SIGNED_MSB    = SLT_SIGNED_LSB;
    localparam int SUB_LSB           = SLT_SIGNED_MSB + 1;
    localparam int SUB_MSB           = SUB_LSB;
    localparam int WRITE_WIDTH_LSB   = SUB_MSB + 1;
    localparam int WRITE_WIDTH_MSB   = WRITE_WIDTH_LSB + 1;
    localparam int WB_SELECT_LSB     = WRITE_WIDTH_MSB + 1;
    localparam int WB_SELECT_MSB     = WB_SELECT_LSB + 1;
    localparam int ALU_OP_LSB        = WB_SELECT_MSB + 1;
    localparam int ALU_OP_MSB        = ALU_OP_LSB + 3;
    localparam int RD_LSB            = ALU_OP_MSB + 1;
    localparam int RD_MSB            = RD_LSB + 4;
    localparam int RS2_DATA_LSB      = RD_MSB + 1;
    localparam int RS2_DATA_MSB      = RS2_DATA_LSB + 31;
    localparam int PC_PLUS_4_LSB     = RS2_DATA_MSB + 1;
    localparam int PC_PLUS_4_MSB     = PC_PLUS_4_LSB + 31;
    localparam int FINAL_B_LSB       = PC_PLUS_4_MSB + 1;
    localparam int FINAL_B_MSB       = FINAL_B_LSB + 31;
    localparam int FINAL_A_LSB       = FINAL_B_MSB + 1;
    localparam int FINAL_A_MSB       = FINAL_A_LSB + 31;

    function automatic logic [ID_EX_PAYLOAD_W-1:0] pack_id_ex(input id_ex_t f);
        return f;
    endfunction

    function automatic id_ex_t unpack_id_ex(input logic [ID_EX_PAYLOAD_W-1:0] v);
        return id_ex_t'(v);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - one-entry skid register with valid
// Purpose: holds the entry accepted while the main register is stalled.
// Ports:   sys_clk/sys_rst  clock, sync active-high reset
//          clr              drop the held entry (flush)
//          load/load_data   capture an entry
//          unload           held entry moved into the main register
//          valid/data       held entry
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W        = 1,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         unload,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            valid <= 1'b0;
            if (CLR_DATA) data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and skid
// Purpose: one pipeline stage register; holds data under backpressure,
//          kills held/incoming entries on flush, counts stalls and bubbles.
// Ports:   sys_clk/sys_rst             clock, sync active-high reset
//          flush                       kill held and incoming entries
//          up_valid/up_ready/up_payload   upstream handshake and data
//          dn_valid/dn_ready/dn_payload   downstream handshake and data
//          stall_cnt                   cycles with dn_valid & !dn_ready
//          bubble_cnt                  entries discarded by flush
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 256,
    parameter bit SKID      = 1'b1,
    parameter bit CLR_DATA  = 1'b0,
    parameter int CNT_W     = 32
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [PAYLOAD_W-1:0] up_payload,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [PAYLOAD_W-1:0] dn_payload,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 dn_valid_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic                 skid_valid;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 up_xfer;
    logic                 dn_xfer;
    logic [1:0]           bubble_inc;

    assign up_xfer    = up_valid && up_ready;
    assign dn_xfer    = dn_valid_q && dn_ready;
    assign dn_valid   = dn_valid_q;
    assign dn_payload = main_q;

    generate
        if (SKID) begin : g_skid
            logic skid_load;
            logic skid_unload;

            // Ready comes only from state, never from dn_ready.
            assign up_ready    = !sys_rst && !skid_valid;
            // Stalled main register accepting a new entry: park it in the skid.
            assign skid_load   = dn_valid_q && !skid_valid && up_xfer && !dn_xfer && !flush;
            assign skid_unload = skid_valid && dn_xfer;

            pipe_skid_buf #(
                .W        (PAYLOAD_W),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .sys_clk   (sys_clk),
                .sys_rst   (sys_rst),
                .clr       (flush),
                .load      (skid_load),
                .load_data (up_payload),
                .unload    (skid_unload),
                .valid     (skid_valid),
                .data      (skid_data)
            );
        end else begin : g_no_skid
            assign up_ready   = !sys_rst && (!dn_valid_q || dn_ready);
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
        end
    endgenerate

    // Main register. When the skid holds an entry it is always older than
    // anything upstream, so it refills main first to keep FIFO order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            dn_valid_q <= 1'b0;
            if (CLR_DATA) main_q <= '0;
        end else if (skid_valid) begin
            if (dn_xfer) main_q <= skid_data;
        end else if (up_xfer && (!dn_valid_q || dn_xfer)) begin
            main_q     <= up_payload;
            dn_valid_q <= 1'b1;
        end else if (dn_xfer) begin
            dn_valid_q <= 1'b0;
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W - 1){1'b0}}, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // A held entry that downstream accepts this cycle is not a bubble.
    assign bubble_inc = 2'(dn_valid_q && !dn_ready) + 2'(skid_valid) + 2'(up_xfer);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            bubble_cnt <= sat_add(bubble_cnt, bubble_inc);
        end else if (dn_valid_q && !dn_ready) begin
            stall_cnt  <= sat_add(stall_cnt, 2'd1);
        end
    end

endmodule
